// File: rtl/memory_map_pkg.sv
// memory_map_pkg: default geometry, derived address map and region decode shared by memory_map.
package memory_map_pkg;

  localparam int DEF_WIDTH        = 16;
  localparam int DEF_ADDR_W       = 15;
  localparam int DEF_RAM_DEPTH    = 16384;
  localparam int DEF_SCREEN_DEPTH = 8192;
  localparam int DEF_KBD_DEPTH    = 4;

  localparam int RAM_BASE    = 0;
  localparam int SCREEN_BASE = RAM_BASE + DEF_RAM_DEPTH;
  localparam int KBD_ADDR    = SCREEN_BASE + DEF_SCREEN_DEPTH;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_SCREEN,
    REGION_KBD,
    REGION_NONE
  } region_t;

  // Regions are laid out back to back from address 0; the keyboard is the single word after the screen.
  function automatic region_t decode_region(input int unsigned addr,
                                            input int unsigned ram_depth,
                                            input int unsigned screen_depth);
    region_t r;
    if (addr < ram_depth)
      r = REGION_RAM;
    else if (addr < ram_depth + screen_depth)
      r = REGION_SCREEN;
    else if (addr == ram_depth + screen_depth)
      r = REGION_KBD;
    else
      r = REGION_NONE;
    return r;
  endfunction

endpackage

// File: rtl/memory_map_kbd_fifo.sv
// kbd_fifo: keyboard code buffer. MEMORY_MAP_KBD_FIFO_EN gives a DEPTH-entry FIFO,
// otherwise it degenerates to a single holding register. Reading the head never pops.
module kbd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             ready,
  output logic [WIDTH-1:0] head
);

`ifdef MEMORY_MAP_KBD_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] LAST       = PW'(CAP - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(CAP);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Push is gated by ready computed before the edge, so a full FIFO refuses a code even when popped.
  always_comb begin
    empty   = (count == '0);
    ready   = (count != FULL_COUNT);
    do_push = push_valid && ready;
    do_pop  = pop && !empty;
    head    = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/memory_map.sv
// memory_map: RAM, screen and keyboard behind one CPU word port, plus a registered display scan port.
// MEMORY_MAP_KBD_FIFO_EN selects the KBD_DEPTH keyboard FIFO instead of a single holding register.
module memory_map
  import memory_map_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int RAM_DEPTH    = DEF_RAM_DEPTH,
  parameter int SCREEN_DEPTH = DEF_SCREEN_DEPTH,
  parameter int KBD_DEPTH    = DEF_KBD_DEPTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [WIDTH-1:0]                in,
  input  logic                            load,
  input  logic [ADDR_W-1:0]               address,
  output logic [WIDTH-1:0]                out,
  input  logic                            kbd_valid,
  input  logic [WIDTH-1:0]                kbd_data,
  output logic                            kbd_ready,
  input  logic [$clog2(SCREEN_DEPTH)-1:0] scan_addr,
  output logic [WIDTH-1:0]                scan_data,
  output logic                            addr_err
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int SCR_AW = $clog2(SCREEN_DEPTH);

  logic [WIDTH-1:0]  ram    [RAM_DEPTH];
  logic [WIDTH-1:0]  screen [SCREEN_DEPTH];
  region_t           region;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;
  logic [WIDTH-1:0]  kbd_head;
  logic              kbd_pop;

  always_comb begin
    region  = decode_region(32'(address), RAM_DEPTH, SCREEN_DEPTH);
    ram_idx = RAM_AW'(address);
    scr_idx = SCR_AW'(32'(address) - 32'(RAM_DEPTH));
    kbd_pop = load && (region == REGION_KBD);
  end

  always_comb begin
    out = '0;
    case (region)
      REGION_RAM:    out = ram[ram_idx];
      REGION_SCREEN: out = screen[scr_idx];
      REGION_KBD:    out = kbd_head;
      default:       out = '0;
    endcase
  end

  // Storage is deliberately left out of reset so program data survives a reset.
  always_ff @(posedge clock) begin
    if (load && region == REGION_RAM)
      ram[ram_idx] <= in;
    if (load && region == REGION_SCREEN)
      screen[scr_idx] <= in;
  end

  // Nonblocking read of the screen gives read-before-write against a same-edge CPU write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_data <= '0;
      addr_err  <= 1'b0;
    end else begin
      scan_data <= screen[scan_addr];
      if (load && region == REGION_NONE)
        addr_err <= 1'b1;
    end
  end

  kbd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (KBD_DEPTH)
  ) u_kbd_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (kbd_valid),
    .push_data  (kbd_data),
    .pop        (kbd_pop),
    .ready      (kbd_ready),
    .head       (kbd_head)
  );

endmodule

// File: tb/tb_memory_map.sv
// tb_memory_map: table-driven, hand-written and randomized checks of memory_map against
// an array/queue model. Keyboard capacity follows MEMORY_MAP_KBD_FIFO_EN (4 entries or 1).
`timescale 1ns/1ps
module tb_memory_map;

  localparam int RAM_WORDS    = 16384;
  localparam int SCREEN_WORDS = 8192;
  localparam int KBD          = RAM_WORDS + SCREEN_WORDS;
`ifdef MEMORY_MAP_KBD_FIFO_EN
  localparam int KBD_CAP = 4;
`else
  localparam int KBD_CAP = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in;
  logic        load;
  logic [14:0] address;
  logic [15:0] out;
  logic        kbd_valid;
  logic [15:0] kbd_data;
  logic        kbd_ready;
  logic [12:0] scan_addr;
  logic [15:0] scan_data;
  logic        addr_err;

  memory_map dut (
    .clock     (clock),
    .reset     (reset),
    .in        (in),
    .load      (load),
    .address   (address),
    .out       (out),
    .kbd_valid (kbd_valid),
    .kbd_data  (kbd_data),
    .kbd_ready (kbd_ready),
    .scan_addr (scan_addr),
    .scan_data (scan_data),
    .addr_err  (addr_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sparse word arrays, a code queue, the sticky error and the expected scan word.
  logic [15:0] ram_m [int];
  logic [15:0] scr_m [int];
  logic [15:0] kbd_q [$];
  logic        err_m = 1'b0;
  logic [15:0] scan_m = '0;
  bit          scan_known = 1'b1;

  typedef struct {
    int          addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit modelRead(input int a, output logic [15:0] v);
    v = '0;
    if (a < RAM_WORDS) begin
      if (!ram_m.exists(a)) return 1'b0;
      v = ram_m[a];
    end else if (a < KBD) begin
      if (!scr_m.exists(a - RAM_WORDS)) return 1'b0;
      v = scr_m[a - RAM_WORDS];
    end else if (a == KBD) begin
      v = (kbd_q.size() > 0) ? kbd_q[0] : 16'h0;
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag);
    logic [15:0] v;
    if (modelRead(int'(address), v))
      checkValue({tag, " out"}, out, v);
    checkValue({tag, " kbd_ready"}, kbd_ready, kbd_q.size() < KBD_CAP);
    checkValue({tag, " addr_err"}, addr_err, err_m);
    if (scan_known)
      checkValue({tag, " scan_data"}, scan_data, scan_m);
  endtask

  task automatic applyStimulus(input int a, input logic [15:0] d, input logic ld,
                               input logic kv, input logic [15:0] kd, input int sa);
    address   = 15'(a);
    in        = d;
    load      = ld;
    kbd_valid = kv;
    kbd_data  = kd;
    scan_addr = 13'(sa);
    #1;
  endtask

  task automatic clockEdge();
    int          a;
    bit          push_ok;
    bit          pop_ok;
    logic [15:0] dropped;
    @(posedge clock);
    a       = int'(address);
    push_ok = kbd_valid && (kbd_q.size() < KBD_CAP);
    pop_ok  = load && (a == KBD) && (kbd_q.size() > 0);
    scan_known = scr_m.exists(int'(scan_addr));
    if (scan_known)
      scan_m = scr_m[int'(scan_addr)];
    if (load) begin
      if (a < RAM_WORDS)      ram_m[a] = in;
      else if (a < KBD)       scr_m[a - RAM_WORDS] = in;
      else if (a > KBD)       err_m = 1'b1;
    end
    if (pop_ok)  dropped = kbd_q.pop_front();
    if (push_ok) kbd_q.push_back(kbd_data);
    #1;
  endtask

  task automatic doReset(input int a, input logic kv, input logic [15:0] kd);
    applyStimulus(a, 16'h0, 1'b0, kv, kd, 0);
    #2 reset = 1'b1;
    #1;
    kbd_q.delete();
    err_m      = 1'b0;
    scan_m     = '0;
    scan_known = 1'b1;
    checkOutput("async reset");
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    kbd_valid = 1'b0;
  endtask

  task automatic kbdIdle(input string tag, input logic [15:0] exp_out, input logic exp_ready);
    applyStimulus(KBD, 16'h0, 1'b0, 1'b0, 16'h0, 0);
    checkValue({tag, " out"}, out, exp_out);
    checkValue({tag, " ready"}, kbd_ready, exp_ready);
    checkOutput(tag);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] pops [4];

    vecs[0] = '{0,     16'hFFFF, 16'hFFFF};
    vecs[1] = '{0,     16'd9999, 16'd9999};
    vecs[2] = '{16383, 16'h1234, 16'h1234};
    vecs[3] = '{16384, 16'd2222, 16'd2222};
    vecs[4] = '{24575, 16'hBEEF, 16'hBEEF};
    vecs[5] = '{100,   16'h0000, 16'h0000};
    vecs[6] = '{24577, 16'h5555, 16'h0000};
    vecs[7] = '{32767, 16'hAAAA, 16'h0000};

    applyStimulus(KBD, 16'h0, 1'b0, 1'b0, 16'h0, 0);
    #2 reset = 1'b1;
    #1;
    checkValue("reset kbd read", out, 16'h0);
    checkValue("reset kbd_ready", kbd_ready, 1'b1);
    checkValue("reset addr_err", addr_err, 1'b0);
    checkValue("reset scan_data", scan_data, 16'h0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;

    $display("[TB] address map vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].data, 1'b1, 1'b0, 16'h0, 0);
      clockEdge();
      applyStimulus(vecs[i].addr, 16'h0, 1'b0, 1'b0, 16'h0, 0);
      checkValue($sformatf("vec%0d read", i), out, vecs[i].exp);
      checkOutput($sformatf("vec%0d", i));
    end
    checkValue("addr_err sticky", addr_err, 1'b1);
    applyStimulus(0, 16'h0, 1'b0, 1'b0, 16'h0, 0);
    checkValue("ram0 after unmapped", out, 16'd9999);
    clockEdge();
    checkValue("scan word0", scan_data, 16'd2222);
    checkValue("out0 beside scan", out, 16'd9999);
    checkValue("addr_err still set", addr_err, 1'b1);

    $display("[TB] scan read-before-write");
    applyStimulus(RAM_WORDS + 5, 16'h1111, 1'b1, 1'b0, 16'h0, 5);
    clockEdge();
    applyStimulus(RAM_WORDS + 5, 16'h2222, 1'b1, 1'b0, 16'h0, 5);
    clockEdge();
    checkValue("scan old word", scan_data, 16'h1111);
    applyStimulus(RAM_WORDS + 5, 16'h0, 1'b0, 1'b0, 16'h0, 5);
    clockEdge();
    checkValue("scan new word", scan_data, 16'h2222);
    checkOutput("scan rbw");

    $display("[TB] reset keeps storage");
    doReset(0, 1'b0, 16'h0);
    applyStimulus(0, 16'h0, 1'b0, 1'b0, 16'h0, 0);
    checkValue("addr_err cleared", addr_err, 1'b0);
    checkValue("ram0 kept", out, 16'd9999);

    $display("[TB] keyboard sequences");
`ifdef MEMORY_MAP_KBD_FIFO_EN
    for (int i = 0; i < 4; i++) begin
      applyStimulus(KBD, 16'h0, 1'b0, 1'b1, 16'(16'h41 + i), 0);
      checkValue($sformatf("push%0d ready", i), kbd_ready, 1'b1);
      clockEdge();
    end
    kbdIdle("kbd full", 16'h41, 1'b0);
    applyStimulus(KBD, 16'h0, 1'b1, 1'b0, 16'h0, 0);
    clockEdge();
    kbdIdle("kbd pop1", 16'h42, 1'b1);
    applyStimulus(KBD, 16'h0, 1'b0, 1'b1, 16'h45, 0);
    clockEdge();
    kbdIdle("kbd refull", 16'h42, 1'b0);
    applyStimulus(KBD, 16'h0, 1'b1, 1'b1, 16'h46, 0);
    clockEdge();
    kbdIdle("full push pop", 16'h43, 1'b1);
    pops[0] = 16'h44;
    pops[1] = 16'h45;
    pops[2] = 16'h0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(KBD, 16'h0, 1'b1, 1'b0, 16'h0, 0);
      clockEdge();
      kbdIdle($sformatf("drain%0d", i), pops[i], 1'b1);
    end
    applyStimulus(KBD, 16'h0, 1'b1, 1'b1, 16'h47, 0);
    clockEdge();
    kbdIdle("empty push pop", 16'h47, 1'b1);
    applyStimulus(KBD, 16'h0, 1'b1, 1'b0, 16'h0, 0);
    clockEdge();
    kbdIdle("empty again", 16'h0, 1'b1);
`else
    applyStimulus(KBD, 16'h0, 1'b0, 1'b1, 16'h41, 0);
    clockEdge();
    kbdIdle("hold push", 16'h41, 1'b0);
    applyStimulus(KBD, 16'h0, 1'b0, 1'b1, 16'h42, 0);
    clockEdge();
    kbdIdle("hold refuse", 16'h41, 1'b0);
    applyStimulus(KBD, 16'h0, 1'b1, 1'b0, 16'h0, 0);
    clockEdge();
    kbdIdle("hold pop", 16'h0, 1'b1);
    applyStimulus(KBD, 16'h0, 1'b0, 1'b1, 16'h50, 0);
    clockEdge();
    applyStimulus(KBD, 16'h0, 1'b1, 1'b1, 16'h51, 0);
    clockEdge();
    kbdIdle("hold full push pop", 16'h0, 1'b1);
    applyStimulus(KBD, 16'h0, 1'b1, 1'b1, 16'h52, 0);
    clockEdge();
    kbdIdle("hold empty push pop", 16'h52, 1'b0);
    applyStimulus(KBD, 16'h0, 1'b1, 1'b0, 16'h0, 0);
    clockEdge();
    pops[0] = 16'h0;
    kbdIdle("hold cleared", pops[0], 1'b1);
`endif

    $display("[TB] reset during push");
    doReset(KBD, 1'b1, 16'h77);
    kbdIdle("mid-push discarded", 16'h0, 1'b1);
    applyStimulus(KBD, 16'h0, 1'b0, 1'b1, 16'h58, 0);
    clockEdge();
    kbdIdle("first push after reset", 16'h58, KBD_CAP > 1);
    applyStimulus(KBD, 16'h0, 1'b1, 1'b0, 16'h0, 0);
    clockEdge();
    kbdIdle("pop after reset", 16'h0, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      int sel;
      int a;
      sel = int'($urandom_range(0, 9));
      if (sel < 3)       a = int'($urandom_range(0, 15));
      else if (sel < 5)  a = RAM_WORDS + int'($urandom_range(0, 15));
      else if (sel < 9)  a = KBD;
      else               a = KBD + 1 + int'($urandom_range(0, 100));
      applyStimulus(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom), int'($urandom_range(0, 15)));
      checkOutput("rand pre");
      clockEdge();
      checkOutput("rand post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_map.md
MEMORY_MAP -- requirements
Module: memory_map

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 15, address width.
REQ-003 SHALL have parameter RAM_DEPTH, default 16384, data RAM words at address 0.
REQ-004 SHALL have parameter SCREEN_DEPTH, default 8192, screen words at address RAM_DEPTH.
REQ-005 SHALL have parameter KBD_DEPTH, default 4, keyboard FIFO entries (power of two, >=2).
REQ-006 SHALL have clock  input  1  rising-edge system clock.
REQ-007 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have in  input  WIDTH  write data.
REQ-009 SHALL have load  input  1  write enable, sampled on clock rising edge.
REQ-010 SHALL have address  input  ADDR_W  CPU word address.
REQ-011 SHALL have out  output  WIDTH  combinational read data at address.
REQ-012 SHALL have kbd_valid  input  1  keyboard code offered.
REQ-013 SHALL have kbd_data  input  WIDTH  keyboard code.
REQ-014 SHALL have kbd_ready  output  1  FIFO can accept a code.
REQ-015 SHALL have scan_addr  input  log2(SCREEN_DEPTH)  display scan address.
REQ-016 SHALL have scan_data  output  WIDTH  registered screen word for display.
REQ-017 SHALL have addr_err  output  1  sticky unmapped-write flag.

Function
REQ-018 Map: RAM [0, RAM_DEPTH-1]; screen [RAM_DEPTH, RAM_DEPTH+SCREEN_DEPTH-1]; KBD_ADDR = RAM_DEPTH+SCREEN_DEPTH; everything above unmapped.
REQ-019 load=1 to RAM/screen SHALL write in at the rising edge; out shows the new value from the following cycle.
REQ-020 out SHALL be combinational (zero latency) for RAM/screen; unmapped reads SHALL return 0.
REQ-021 Read at KBD_ADDR SHALL return FIFO head, or 0 when empty; reads SHALL NOT pop.
REQ-022 load=1 at KBD_ADDR SHALL pop one entry (data ignored); pop on empty SHALL be ignored.
REQ-023 kbd_ready SHALL equal !full; push occurs when kbd_valid & kbd_ready at rising edge.
REQ-024 Simultaneous push and pop, not full and not empty: count unchanged, head advances, code appended.
REQ-025 Push while empty plus pop same edge: pop ignored, code stored, count=1.
REQ-026 Full plus pop same edge: push refused (kbd_ready=0), count drops by 1.
REQ-027 FIFO pointers SHALL wrap modulo KBD_DEPTH.
REQ-028 scan_data SHALL be the screen word at scan_addr registered one clock later; a CPU write to that same word on the same edge SHALL yield the old value (read-before-write).
REQ-029 load=1 at an unmapped address SHALL set addr_err, with no storage changed.

Reset
REQ-030 reset SHALL clear FIFO (count 0, pointers 0), addr_err=0, scan_data=0, asynchronously.
REQ-031 After reset kbd_ready=1; reading KBD_ADDR returns 0.
REQ-032 RAM and screen contents SHALL NOT be cleared by reset.
REQ-033 Reset mid-push SHALL discard the code; first edge after release behaves normally.

Configuration
REQ-034 Macro MEMORY_MAP_KBD_FIFO_EN defined: keyboard path is the KBD_DEPTH FIFO of REQ-021..027.
REQ-035 Macro undefined: single holding register; kbd_ready=!occupied; pop clears it; KBD_DEPTH ignored.

Structure
REQ-036 Shared package SHALL hold the default widths/depths and the derived KBD_ADDR and region-base constants.
REQ-037 Keyboard FIFO SHALL be one sub-module, kbd_fifo; RAM/screen arrays and decode stay in memory_map.

Verification
REQ-038 Write -1 at 0, then 9999 at 0 -> out reads 65535 then 9999 at address 0.
REQ-039 Write 2222 at 16384 (screen word 0), scan_addr=0 -> scan_data 2222 one clock later; out at 0 unaffected.
REQ-040 Push 0x41,0x42,0x43,0x44 -> kbd_ready=0 after fourth; read 24576 = 0x41; pop -> 0x42; kbd_ready=1.
REQ-041 Full FIFO, kbd_valid=1 plus pop same edge -> code refused, count 3; empty plus push plus pop -> count 1.
REQ-042 load=1 at 24577 -> addr_err=1 sticky, out=0; reset -> addr_err=0, RAM word 0 still 9999.
REQ-043 Rebuild without MEMORY_MAP_KBD_FIFO_EN: push 0x41 -> kbd_ready=0; second code refused; pop -> read 0, kbd_ready=1.
